// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller/scheduler and its refresh timer.
// Call codes match the one-hot iCall vector of sdram_funcmod.
package sdram_pkg;

  // One-hot call codes driven onto sdram_funcmod iCall
  localparam logic [3:0] CALL_WR   = 4'b1000;
  localparam logic [3:0] CALL_RD   = 4'b0100;
  localparam logic [3:0] CALL_REF  = 4'b0010;
  localparam logic [3:0] CALL_INIT = 4'b0001;
  localparam logic [3:0] CALL_NONE = 4'b0000;

  // Refresh interval in clock cycles: 7.8 us at 133 MHz
  localparam logic [10:0] TREF_DEFAULT = 11'd1040;
  // Idle cycles with no call between two funcmod calls (legal range 1..3)
  localparam logic [1:0]  TGAP_DEFAULT = 2'd1;

  // funcmod timing constants, in clock cycles at 133 MHz
  localparam int T100US = 13300;
  localparam int TRP    = 3;
  localparam int TRRC   = 9;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_GAP  = 3'd2,
    ST_REF  = 3'd3,
    ST_WR   = 3'd4,
    ST_RD   = 3'd5
  } state_e;

  // Fixed-priority arbitration: pending refresh, then write, then read.
  // Returns CALL_NONE when nothing is waiting.
  function automatic logic [3:0] grant_call(input logic is_ref, input logic [1:0] req);
    logic [3:0] call;
    call = CALL_NONE;
    if (is_ref) begin
      call = CALL_REF;
    end else if (req[1]) begin
      call = CALL_WR;
    end else if (req[0]) begin
      call = CALL_RD;
    end
    return call;
  endfunction

  // Busy state that owns a granted call code
  function automatic state_e call_state(input logic [3:0] call);
    state_e st;
    case (call)
      CALL_REF: st = ST_REF;
      CALL_WR:  st = ST_WR;
      CALL_RD:  st = ST_RD;
      default:  st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sdram_reftimer.sv
// Auto-refresh interval timer. Counts while enabled, raises a pending flag on
// every wrap, and latches a sticky error when a wrap finds the flag still set.
module sdram_reftimer
  import sdram_pkg::*;
#(
  parameter logic [10:0] TREF = TREF_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,        // timer runs only once init has completed
  input  logic clr_pend,  // scheduler has granted the pending refresh
  output logic is_ref,
  output logic ref_err
);

  logic [10:0] c1_q, c1_d;
  logic        is_ref_q, is_ref_d;
  logic        ref_err_q, ref_err_d;
  logic        wrap;

  // Next counter value, pending flag and sticky error
  always_comb begin
    wrap = en && (c1_q == (TREF - 11'd1));

    c1_d = c1_q;
    if (en) begin
      c1_d = wrap ? 11'd0 : (c1_q + 11'd1);
    end

    // A wrap on the same edge as a grant starts a fresh interval, so the
    // set wins over the clear and no error is flagged for it.
    is_ref_d = is_ref_q;
    if (clr_pend) begin
      is_ref_d = 1'b0;
    end
    if (wrap) begin
      is_ref_d = 1'b1;
    end

    // No queue of missed refreshes: one pending flag, plus a sticky error
    ref_err_d = ref_err_q | (wrap & is_ref_q & ~clr_pend);
  end

  // Timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q      <= 11'd0;
      is_ref_q  <= 1'b0;
      ref_err_q <= 1'b0;
    end else begin
      c1_q      <= c1_d;
      is_ref_q  <= is_ref_d;
      ref_err_q <= ref_err_d;
    end
  end

  assign is_ref  = is_ref_q;
  assign ref_err = ref_err_q;

endmodule

// File: rtl/sdram_ctrlmod.sv
// SDRAM controller/scheduler in front of sdram_funcmod. Runs power-up init
// once after reset, then arbitrates refresh, write-burst and read onto the
// funcmod one-hot call/done handshake. All outputs are registered.
//
// Handshakes:
//   user side   : iCall[n] is raised and held until the matching one-cycle
//                 oDone[n] pulse; dropping it early does not abort the
//                 operation, which still completes and still pulses oDone.
//   funcmod side: oCall holds one one-hot code until a one-cycle iDone, drops
//                 to zero on that same edge, and stays zero for TGAP cycles
//                 in GAP before another call can be granted.
module sdram_ctrlmod
  import sdram_pkg::*;
#(
  parameter logic [10:0] TREF = TREF_DEFAULT,
  parameter logic [1:0]  TGAP = TGAP_DEFAULT
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] iCall,
  output logic [1:0] oDone,
  output logic       oReady,
  output logic       oRefErr,
  output logic [3:0] oCall,
  input  logic       iDone,
  output logic [2:0] dbg_state
);

  state_e     state_q, state_d;
  logic [1:0] gap_q, gap_d;
  logic [3:0] call_q, call_d;
  logic [1:0] done_q, done_d;
  logic       ready_q, ready_d;
  logic       is_ref;
  logic       ref_err;
  logic       clr_pend;
  logic [3:0] grant;

  sdram_reftimer #(
    .TREF (TREF)
  ) u_reftimer (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .en       (ready_q),
    .clr_pend (clr_pend),
    .is_ref   (is_ref),
    .ref_err  (ref_err)
  );

  // Arbitration result, only acted on in IDLE
  assign grant = grant_call(is_ref, iCall);

  // State register and gap counter
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_INIT;
      gap_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gap_d   = 2'd0;
    case (state_q)
      ST_INIT: begin
        if (iDone) begin
          state_d = ST_GAP;
        end
      end
      ST_IDLE: begin
        if (grant != CALL_NONE) begin
          state_d = call_state(grant);
        end
      end
      ST_GAP: begin
        // Stray iDone here is ignored; only the cycle count matters
        gap_d = gap_q + 2'd1;
        if (gap_q == (TGAP - 2'd1)) begin
          state_d = ST_IDLE;
          gap_d   = 2'd0;
        end
      end
      ST_REF, ST_WR, ST_RD: begin
        if (iDone) begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    call_d   = CALL_NONE;
    done_d   = 2'b00;
    ready_d  = ready_q;
    clr_pend = 1'b0;
    case (state_q)
      ST_INIT: begin
        // User requests are not looked at until init completes
        if (iDone) begin
          ready_d = 1'b1;
        end else begin
          call_d = CALL_INIT;
        end
      end
      ST_IDLE: begin
        call_d   = grant;
        clr_pend = (grant == CALL_REF);
      end
      ST_REF: begin
        call_d = iDone ? CALL_NONE : call_q;
      end
      ST_WR: begin
        call_d = iDone ? CALL_NONE : call_q;
        done_d = iDone ? 2'b10 : 2'b00;
      end
      ST_RD: begin
        call_d = iDone ? CALL_NONE : call_q;
        done_d = iDone ? 2'b01 : 2'b00;
      end
      default: begin
        call_d = CALL_NONE;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      call_q  <= CALL_NONE;
      done_q  <= 2'b00;
      ready_q <= 1'b0;
    end else begin
      call_q  <= call_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign oCall     = call_q;
  assign oDone     = done_q;
  assign oReady    = ready_q;
  assign oRefErr   = ref_err;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Bench for sdram_ctrlmod. Two instances: u_a with the default refresh interval
// and u_b with TREF = 50, exercised one after the other while the other sits
// in reset. A monitor watches the selected instance's outputs on the falling
// edge; every change of {oCall, oDone, oReady, oRefErr} becomes an event
// tagged with the number of cycles since the previous change, and is compared
// against hand-computed events pushed into exp_q before each scenario.
module tb_sdram_ctrlmod;
  import sdram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Relative cycle 0 is the fourth rising edge
  localparam int BASE = 4;

  logic       rst_a, rst_b;
  logic [1:0] ucall;
  logic       done_m, stray;
  logic       sel;

  logic [3:0] ocall_a, ocall_b;
  logic [1:0] odone_a, odone_b;
  logic       ordy_a, ordy_b, oerr_a, oerr_b;
  logic [2:0] dbg_a, dbg_b;
  logic       idone_a, idone_b;

  assign idone_a = (sel == 1'b0) ? (done_m | stray) : 1'b0;
  assign idone_b = (sel == 1'b1) ? (done_m | stray) : 1'b0;

  sdram_ctrlmod u_a (
    .CLOCK     (clk),
    .RESET     (rst_a),
    .iCall     (ucall),
    .oDone     (odone_a),
    .oReady    (ordy_a),
    .oRefErr   (oerr_a),
    .oCall     (ocall_a),
    .iDone     (idone_a),
    .dbg_state (dbg_a)
  );

  sdram_ctrlmod #(.TREF(11'd50), .TGAP(2'd1)) u_b (
    .CLOCK     (clk),
    .RESET     (rst_b),
    .iCall     (ucall),
    .oDone     (odone_b),
    .oReady    (ordy_b),
    .oRefErr   (oerr_b),
    .oCall     (ocall_b),
    .iDone     (idone_b),
    .dbg_state (dbg_b)
  );

  logic [3:0] sel_call;
  logic [1:0] sel_done;
  logic       sel_rdy, sel_err, sel_rst;
  assign sel_call = sel ? ocall_b : ocall_a;
  assign sel_done = sel ? odone_b : odone_a;
  assign sel_rdy  = sel ? ordy_b  : ordy_a;
  assign sel_err  = sel ? oerr_b  : oerr_a;
  assign sel_rst  = sel ? rst_b   : rst_a;

  // ---------------- funcmod model ----------------
  // A call first seen on falling edge N gets iDone high from N+lat-1 to N+lat,
  // so oCall stays high for exactly lat cycles. Reset aborts the call.
  int lat_init, lat_ref, lat_wr, lat_rd;

  initial begin : funcmod_model
    int lat;
    done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (sel_rst && sel_call != CALL_NONE) begin
        case (sel_call)
          CALL_INIT: lat = lat_init;
          CALL_REF:  lat = lat_ref;
          CALL_WR:   lat = lat_wr;
          default:   lat = lat_rd;
        endcase
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (!sel_rst) break;
        end
        if (sel_rst) begin
          done_m = 1'b1;
          @(negedge clk);
          done_m = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_evt = 0;

  task automatic push(input logic [3:0] c, input logic [1:0] d,
                      input logic r, input logic e, input int dt);
    logic [11:0] dt12;
    dt12 = dt[11:0];
    exp_q.push_back({c, d, r, e, dt12});
  endtask

  logic [7:0]  prev_v = 8'h00;
  int unsigned since  = 0;

  // Monitor: every output change is one event, checked against exp_q
  always @(negedge clk) begin : monitor
    logic [7:0]  v;
    logic [19:0] got, exp;
    v = {sel_call, sel_done, sel_rdy, sel_err};
    since++;
    if (v != prev_v) begin
      got = {v, since[11:0]};
      n_evt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL event#%0d unexpected: call=%b done=%b rdy=%b err=%b dt=%0d",
                 n_evt, got[19:16], got[15:14], got[13], got[12], got[11:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got != exp) begin
          n_bad++;
          $display("FAIL event#%0d got call=%b done=%b rdy=%b err=%b dt=%0d, expected call=%b done=%b rdy=%b err=%b dt=%0d",
                   n_evt, got[19:16], got[15:14], got[13], got[12], got[11:0],
                   exp[19:16], exp[15:14], exp[13], exp[12], exp[11:0]);
        end
      end
      prev_v = v;
      since  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Continue just after relative rising edge k
  task automatic at(input int k);
    while (cyc < BASE + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for oDone[idx], then drop the matching request bit
  task automatic wait_done(input int idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sel_done[idx]) seen = 1'b1;
    end
    ucall[idx] = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_wait bit=%0d: no pulse within %0d cycles", idx, budget);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stimulus
    rst_a = 1'b0; rst_b = 1'b0; ucall = 2'b00; stray = 1'b0; sel = 1'b0;
    lat_init = 20; lat_ref = 5; lat_wr = 520; lat_rd = 8;

    // Init on u_a: 0001 for 20 cycles, then ready on the drop edge
    push(CALL_INIT, 2'b00, 1'b0, 1'b0, 5);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 20);
    at(0); rst_a = 1'b1;

    // Write burst, 520-cycle funcmod latency
    push(CALL_WR,   2'b00, 1'b1, 1'b0, 5);
    push(CALL_NONE, 2'b10, 1'b1, 1'b0, 520);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 1);
    at(25); ucall = 2'b10;
    wait_done(1, 600);

    // Write and read together: write first, read TGAP+1 after write drops
    lat_wr = 6;
    push(CALL_WR,   2'b00, 1'b1, 1'b0, 1);
    push(CALL_NONE, 2'b10, 1'b1, 1'b0, 6);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 1);
    push(CALL_RD,   2'b00, 1'b1, 1'b0, 1);
    push(CALL_NONE, 2'b01, 1'b1, 1'b0, 8);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 1);
    at(547); ucall = 2'b11;
    wait_done(1, 50);
    wait_done(0, 50);

    // Stray iDone in IDLE: no output change expected
    at(570); stray = 1'b1;
    at(571); stray = 1'b0;

    // Reset during a read, then init reruns
    lat_rd = 40; lat_init = 10;
    push(CALL_RD,   2'b00, 1'b1, 1'b0, 16);
    push(CALL_NONE, 2'b00, 1'b0, 1'b0, 9);
    push(CALL_INIT, 2'b00, 1'b0, 1'b0, 6);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 10);
    push(CALL_NONE, 2'b00, 1'b0, 1'b0, 14);
    at(580); ucall = 2'b01;
    at(590); rst_a = 1'b0; ucall = 2'b00;
    at(595); rst_a = 1'b1;
    at(620); rst_a = 1'b0;

    // u_b, TREF = 50: init then a refresh every 50 cycles
    at(625); sel = 1'b1; lat_init = 20; lat_ref = 5;
    push(CALL_INIT, 2'b00, 1'b0, 1'b0, 11);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 20);
    push(CALL_REF,  2'b00, 1'b1, 1'b0, 51);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 5);
    push(CALL_REF,  2'b00, 1'b1, 1'b0, 45);
    push(CALL_NONE, 2'b00, 1'b1, 1'b0, 5);
    at(630); rst_b = 1'b1;

    // 120-cycle write spans two wraps: error, then refresh right after gap.
    // The requester drops iCall mid-write; oDone must still pulse.
    lat_wr = 120;
    push(CALL_WR,   2'b00, 1'b1, 1'b0, 4);
    push(CALL_WR,   2'b00, 1'b1, 1'b1, 90);
    push(CALL_NONE, 2'b10, 1'b1, 1'b1, 30);
    push(CALL_NONE, 2'b00, 1'b1, 1'b1, 1);
    push(CALL_REF,  2'b00, 1'b1, 1'b1, 1);
    push(CALL_NONE, 2'b00, 1'b1, 1'b1, 5);
    push(CALL_REF,  2'b00, 1'b1, 1'b1, 14);
    push(CALL_NONE, 2'b00, 1'b1, 1'b1, 5);
    at(760); ucall = 2'b10;
    at(800); ucall = 2'b00;

    // Read arrives in the same IDLE cycle as a refresh: refresh wins
    lat_rd = 8;
    push(CALL_REF,  2'b00, 1'b1, 1'b1, 45);
    push(CALL_NONE, 2'b00, 1'b1, 1'b1, 5);
    push(CALL_RD,   2'b00, 1'b1, 1'b1, 2);
    push(CALL_NONE, 2'b01, 1'b1, 1'b1, 8);
    push(CALL_NONE, 2'b00, 1'b1, 1'b1, 1);
    at(951); ucall = 2'b01;
    wait_done(0, 50);

    push(CALL_REF,  2'b00, 1'b1, 1'b1, 34);
    push(CALL_NONE, 2'b00, 1'b1, 1'b1, 5);
    push(CALL_NONE, 2'b00, 1'b0, 1'b0, 3);
    at(1010); rst_b = 1'b0;

    at(1020);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_events: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_ctrlmod.md
Name: sdram_ctrlmod

Overview:
- Controller and scheduler placed between user logic and sdram_funcmod.
- After reset it runs the SDRAM power-up init exactly once, then issues periodic auto-refresh.
- It arbitrates user write-burst and read requests onto the funcmod one-hot call/done handshake.
- Refresh has priority over user traffic; user address and data pass straight through to funcmod.

Parameters:
- TREF, 11'd1040, refresh interval in CLOCK cycles (7.8 us at 133 MHz).
- TGAP, 2'd1, minimum idle cycles with oCall == 0 between two funcmod calls (range 1..3).

Ports:
- CLOCK  input  1  system clock, 133 MHz.
- RESET  input  1  asynchronous active-low reset.
- iCall  input  2  user request: [1] = write burst, [0] = read. Held high until the matching oDone.
- oDone  output  2  one-cycle completion pulse: [1] = write, [0] = read.
- oReady  output  1  high once init is complete; stays high until the next reset.
- oRefErr  output  1  sticky flag: a refresh deadline was missed.
- oCall  output  4  to sdram_funcmod iCall: [3] = write, [2] = read, [1] = refresh, [0] = init.
- iDone  input  1  from sdram_funcmod oDone; one-cycle pulse.

Behaviour:
- Reset values: oCall = 0, oDone = 0, oReady = 0, oRefErr = 0; state = INIT; refresh counter C1 = 0; refresh pending flag isRef = 0; gap counter = 0.
- All outputs are registered. User addr/data are not routed through this block: the top level wires them to funcmod and holds them stable while iCall is high.
- States: INIT, IDLE, GAP, REF, WR, RD.
- INIT
  - oCall = 4'b0001 from the first cycle after reset is released.
  - On iDone: oCall = 0, oReady = 1, C1 cleared, go to GAP.
  - User iCall is ignored while in INIT.
- Refresh timer
  - Runs only while oReady = 1. Counts 0..TREF-1, then wraps to 0 and sets isRef.
  - If a wrap occurs while isRef is already 1, set oRefErr (sticky until reset). isRef stays 1; there is no pending-count queue.
- IDLE: arbitration is evaluated each cycle with fixed priority isRef > iCall[1] > iCall[0].
  - isRef: oCall = 4'b0010, clear isRef on that same edge, go to REF.
  - iCall[1]: oCall = 4'b1000, go to WR.
  - iCall[0]: oCall = 4'b0100, go to RD.
  - Nothing pending: stay in IDLE.
- REF, WR, RD
  - oCall is held constant until iDone = 1.
  - On the iDone edge: oCall = 0, and for WR/RD pulse oDone[1]/oDone[0] for exactly one cycle. Then go to GAP.
  - Requests that arrive meanwhile wait. A refresh expiry during WR/RD only sets isRef.
- GAP
  - Hold oCall = 0 for TGAP cycles, then go to IDLE. This guarantees funcmod has returned to step 0.
- Latency
  - Request seen in IDLE → oCall asserted on the next edge.
  - iDone → oDone on the same edge as oCall drops.
  - Earliest next call: TGAP+1 cycles after oCall drops.
- Boundary conditions
  - iCall[1] and iCall[0] both high: write is served first. Read is served after the write plus gap, provided iCall[0] is still held.
  - Requester drops iCall mid-operation: the operation still completes and oDone still pulses.
  - iDone while in IDLE or GAP: ignored.
  - Reset mid-operation: every output returns to its reset value immediately, and init reruns. funcmod shares the same RESET.
  - Refresh and user request arriving in the same IDLE cycle: refresh wins. The user request is granted after refresh and gap.

Decomposition:
- Shared package sdram_pkg holds:
  - call one-hot constants: CALL_WR = 4'b1000, CALL_RD = 4'b0100, CALL_REF = 4'b0010, CALL_INIT = 4'b0001;
  - state encodings;
  - default TREF;
  - funcmod timing constants (T100US, TRP, TRRC) for bench reuse.
- One natural sub-module: sdram_reftimer (refresh counter, isRef, oRefErr; inputs: enable and clear-pending).

Test Plan:
1. Release RESET, bench funcmod model returns iDone 20 cycles after oCall = 0001 → oCall = 0001 for 20 cycles, then 0; oReady = 1 next edge; no other call within TGAP.
2. After init, iCall = 2'b10, model iDone after 520 cycles → oCall = 1000 one cycle after the request, held 520 cycles; oDone = 2'b10 for exactly 1 cycle; then oCall = 0 for TGAP cycles.
3. TREF = 50, no user traffic → oCall = 0010 every 50 cycles (±1) after oReady; oRefErr stays 0.
4. TREF = 50, write held busy 120 cycles → one refresh issued immediately after write completion plus gap; oRefErr = 1 because a second wrap hit while isRef was pending.
5. iCall = 2'b11 in IDLE, read model latency 8 cycles → write granted first, oDone = 10; read granted TGAP+1 cycles later, oDone = 01.
6. Assert RESET low during an RD with oCall = 0100 → next cycle oCall = 0, oReady = 0, oDone = 0; after release, oCall = 0001 again.
